// File: rtl/gpr_write_arbiter.sv
// Round-robin write arbiter onto the shared GPR C bus; registers the winning write as a load strobe.
// Optional burst locking is compiled in with `define GPR_ARB_LOCK_EN.

module gpr_wr_lane #(
  parameter int NUM_REG = 8,
  parameter int ADDR_W  = 3
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_REG-1:0] hot,
  output logic               in_range
);
  always_comb begin
    hot = '0;
    for (int r = 0; r < NUM_REG; r++) hot[r] = (32'(addr) == r);
  end

  assign in_range = 32'(addr) < NUM_REG;
endmodule

module gpr_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int ADDR_W  = 3,
  parameter int WIDTH   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       hold,
`ifdef GPR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [WIDTH-1:0]           C_bus,
  output logic [NUM_REG-1:0]         load,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       addr_err
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_v;
  logic [NUM_REQ-1:0][WIDTH-1:0]   data_v;
  logic [NUM_REQ-1:0][NUM_REG-1:0] lane_hot;
  logic [NUM_REQ-1:0]              lane_ok;

  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] win_id;
  logic [ID_W:0]   idx;
  logic            found;
  logic            grant;

`ifdef GPR_ARB_LOCK_EN
  logic            locked;
  logic [ID_W-1:0] lock_id;
`endif

  assign addr_v = req_addr;
  assign data_v = req_data;

  // Address decode is done per requester so the winner mux only selects a ready-made strobe.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    gpr_wr_lane #(.NUM_REG(NUM_REG), .ADDR_W(ADDR_W)) u_lane (
      .addr     (addr_v[i]),
      .hot      (lane_hot[i]),
      .in_range (lane_ok[i])
    );
  end

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = idx[ID_W-1:0];
      end
    end
`ifdef GPR_ARB_LOCK_EN
    // A locked owner excludes everyone else, even while it is idle or stalled.
    if (locked) begin
      found  = req_valid[lock_id];
      win_id = lock_id;
    end
`endif
  end

  assign grant     = found & ~hold & ~rst;
  assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C_bus       <= '0;
      load        <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      addr_err    <= 1'b0;
      last_grant  <= ID_W'(NUM_REQ-1);
`ifdef GPR_ARB_LOCK_EN
      locked      <= 1'b0;
      lock_id     <= '0;
`endif
    end else begin
      grant_valid <= grant;
      if (grant) begin
        last_grant <= win_id;
        C_bus      <= data_v[win_id];
        grant_id   <= win_id;
        load       <= lane_hot[win_id];
        addr_err   <= ~lane_ok[win_id];
      end else begin
        load       <= '0;
        addr_err   <= 1'b0;
      end
`ifdef GPR_ARB_LOCK_EN
      if (grant) begin
        locked  <= req_lock[win_id];
        lock_id <= win_id;
      end else if (locked && !req_valid[lock_id]) begin
        locked  <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Randomized + directed bench for gpr_write_arbiter against a behavioural round-robin model.
// Lock scenarios are exercised when built with GPR_ARB_LOCK_EN.

module tb_gpr_write_arbiter;
  localparam int N  = 4;
  localparam int NR = 6;
  localparam int AW = 3;
  localparam int W  = 24;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [N-1:0]         valid = '0;
  logic [N-1:0][AW-1:0] addr  = '0;
  logic [N-1:0][W-1:0]  data  = '0;
`ifdef GPR_ARB_LOCK_EN
  logic [N-1:0]         lock  = '0;
`endif

  logic [N-1:0]  req_ready;
  logic [W-1:0]  C_bus;
  logic [NR-1:0] load;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          addr_err;

  gpr_write_arbiter #(.NUM_REQ(N), .NUM_REG(NR), .ADDR_W(AW), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (valid),
    .req_ready   (req_ready),
    .req_addr    (addr),
    .req_data    (data),
    .hold        (hold),
`ifdef GPR_ARB_LOCK_EN
    .req_lock    (lock),
`endif
    .C_bus       (C_bus),
    .load        (load),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            m_ptr;
  bit            m_locked;
  int            m_lock_id;
  int            wait_cnt [N];
  logic [W-1:0]  e_cbus;
  logic [NR-1:0] e_load;
  logic          e_gv;
  logic [IW-1:0] e_gid;
  logic          e_err;
  logic [N-1:0]  last_rdy;

  task automatic model_reset();
    m_ptr = N-1; m_locked = 0; m_lock_id = 0;
    e_cbus = '0; e_load = '0; e_gv = 0; e_gid = '0; e_err = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  function automatic int m_winner();
    if (rst || hold) return -1;
    if (m_locked) return valid[m_lock_id] ? m_lock_id : -1;
    for (int k = 1; k <= N; k++)
      if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Inputs are already driven; checks ready, clocks once, checks registered outputs.
  task automatic step();
    int w;
    logic [N-1:0] er;
    #2;
    w  = m_winner();
    er = (w < 0) ? '0 : (N'(1) << w);
    check("ready", 64'(req_ready), 64'(er));
    last_rdy = req_ready;
    @(posedge clk);
    if (rst) model_reset();
    else if (w >= 0) begin
`ifndef GPR_ARB_LOCK_EN
      check("fair", 64'(wait_cnt[w] <= N-1), 64'(1));
      for (int i = 0; i < N; i++)
        wait_cnt[i] = (i != w && valid[i]) ? wait_cnt[i] + 1 : 0;
`endif
      m_ptr  = w;
      e_cbus = data[w];
      e_gid  = IW'(w);
      e_gv   = 1;
      if (int'(addr[w]) < NR) begin e_load = NR'(1) << addr[w]; e_err = 0; end
      else                    begin e_load = '0;                e_err = 1; end
`ifdef GPR_ARB_LOCK_EN
      m_locked  = lock[w];
      m_lock_id = w;
`endif
    end else begin
      e_gv = 0; e_load = '0; e_err = 0;
      for (int i = 0; i < N; i++) if (!valid[i]) wait_cnt[i] = 0;
      if (m_locked && !valid[m_lock_id]) m_locked = 0;
    end
    #1;
    check("c_bus",    64'(C_bus),       64'(e_cbus));
    check("load",     64'(load),        64'(e_load));
    check("gnt_vld",  64'(grant_valid), 64'(e_gv));
    check("gnt_id",   64'(grant_id),    64'(e_gid));
    check("addr_err", 64'(addr_err),    64'(e_err));
  endtask

  // Requesters keep a stalled request stable; others get fresh random traffic.
  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (!(valid[i] && !last_rdy[i])) begin
        valid[i] = 1'($urandom);
        addr[i]  = AW'($urandom);
        data[i]  = W'($urandom);
      end
`ifdef GPR_ARB_LOCK_EN
      lock[i] = 1'($urandom);
`endif
    end
    hold = ($urandom % 8) == 0;
  endtask

  initial begin
    model_reset();
    last_rdy = '0;

    // Reset state, then release with everyone requesting
    valid = '1;
    step();
    check("rst_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    step();
    check("rst_first_id", 64'(grant_id), 64'(0));

    // Single write
    valid = 4'b0100; addr[2] = 3'd5; data[2] = 24'hABCDEF;
    step();
    check("sw_load",  64'(load),        64'(6'b100000));
    check("sw_cbus",  64'(C_bus),       64'(24'hABCDEF));
    check("sw_id",    64'(grant_id),    64'(2));
    check("sw_gv",    64'(grant_valid), 64'(1));
    valid = '0;
    step();
    check("sw_load_off", 64'(load), 64'(0));

    // Round-robin between 0 and 1
    valid = 4'b0011; addr[0] = 3'd1; addr[1] = 3'd2;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_id",   64'(grant_id), 64'(i % 2));
      check("rr_load", 64'(load),     64'((i % 2) ? 6'b000100 : 6'b000010));
    end

    // Hold stalls requester 3
    valid = 4'b1000; addr[3] = 3'd0; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_load", 64'(load), 64'(0));
    end
    hold = 1'b0;
    step();
    check("hold_rel_id", 64'(grant_id),    64'(3));
    check("hold_rel_gv", 64'(grant_valid), 64'(1));

    // Out-of-range address is consumed without a load
    valid = 4'b0010; addr[1] = 3'd7;
    step();
    check("aerr_rdy",  64'(last_rdy), 64'(4'b0010));
    check("aerr_load", 64'(load),     64'(0));
    check("aerr_flag", 64'(addr_err), 64'(1));
    valid = '0;
    step();
    check("aerr_clr", 64'(addr_err), 64'(0));

`ifdef GPR_ARB_LOCK_EN
    // Locked burst from 0 keeps requester 1 waiting
    valid = 4'b0011; addr[0] = 3'd3; addr[1] = 3'd4;
    lock[0] = 1'b1; step(); check("lk_id0", 64'(grant_id), 64'(0));
    step();                 check("lk_id1", 64'(grant_id), 64'(0));
    lock[0] = 1'b0; step(); check("lk_id2", 64'(grant_id), 64'(0));
    step();                 check("lk_id3", 64'(grant_id), 64'(1));
    valid = '0; lock = '0;
    step();
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset mid-transfer
    hold = 1'b0; valid = '1;
    for (int i = 0; i < N; i++) addr[i] = AW'(i);
    step();
    rst = 1'b1;
    #1;
    check("arst_load", 64'(load),        64'(0));
    check("arst_cbus", 64'(C_bus),       64'(0));
    check("arst_gv",   64'(grant_valid), 64'(0));
    check("arst_id",   64'(grant_id),    64'(0));
    check("arst_err",  64'(addr_err),    64'(0));
    check("arst_rdy",  64'(req_ready),   64'(0));
    model_reset();
    step();
    rst = 1'b0;
    step();
    check("arst_first_id", 64'(grant_id), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpr_write_arbiter.md
# gpr_write_arbiter

- Shares the single 24-bit C bus among several datapath requesters and converts each accepted write into a one-cycle load strobe to one general-purpose register.
- Sits between the write-back sources (ALU, memory read port, immediate/microcode path) and the GPR bank.
- Arbitrates round-robin and handshakes with each requester using valid/ready.
- Registers the winning data and address so the GPRs capture it on the following clock edge.

## Interface

Parameters:
- NUM_REQ, 4, number of write requesters (2..8)
- NUM_REG, 8, number of GPRs driven (1..2**ADDR_W)
- ADDR_W, 3, register address width
- WIDTH, 24, data width; matches the GPR C_bus

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept; combinational
- req_addr  in  NUM_REQ*ADDR_W  target register; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- hold  in  1  freeze from microcontroller; no acceptance while high
- C_bus  out  WIDTH  registered write data to all GPRs
- load  out  NUM_REG  registered one-hot GPR load strobes
- grant_valid  out  1  registered; high in the cycle load is driven
- grant_id  out  $clog2(NUM_REQ)  registered index of the requester driving C_bus
- addr_err  out  1  registered one-cycle pulse for an accepted write with addr >= NUM_REG

## Operation

- **Reset:** while rst is high, all outputs are 0 and last_grant = NUM_REQ-1, so requester 0 has top priority after reset. Reset applied mid-transfer drops any pending load; no GPR is written.
- **Arbitration (combinational):**
  - Search req_valid starting from last_grant+1, wrapping at NUM_REQ.
  - The first valid requester wins, and only that requester's req_ready is 1.
  - If hold = 1, all req_ready bits are 0.
- **Accept:** an accept occurs when req_valid[i] & req_ready[i]. On the accepting edge:
  - last_grant <= i.
  - C_bus <= data[i].
  - grant_id <= i.
  - grant_valid <= 1.
  - If addr < NUM_REG: load <= one-hot(addr), addr_err <= 0.
  - Otherwise: load <= 0, addr_err <= 1.
- **No accept:** load, grant_valid and addr_err go to 0. C_bus and grant_id hold their last values.
- **Throughput:** at most one accept per cycle. Back-to-back accepts from different requesters are allowed.
- **Fairness:** a continuously requesting requester waits at most NUM_REQ-1 accepts of others.
- **Protocol:** requesters must hold addr/data stable while valid && !ready. The block does not check this.

## Timing

- Request presented in cycle N and accepted at edge E_N:
  - load and C_bus are valid during cycle N+1.
  - The GPR captures the data at edge E_N+1.
  - Total latency: 2 edges from request to register update.
- req_ready depends combinationally on req_valid, hold and lock state. It never depends on req_data.
- hold asserted in cycle N blocks acceptance at edge E_N. A transfer already registered (load high in cycle N) still completes.
- The lock state changes only at clock edges.

## Configuration

- **Macro:** GPR_ARB_LOCK_EN.
- **When defined:** adds input req_lock (NUM_REQ bits).
  - If requester i is accepted with req_lock[i] = 1, the arbiter becomes locked to i. Only i may receive ready on following cycles, and the round-robin pointer is not advanced.
  - The lock is released at an accept of i with req_lock[i] = 0, or at any edge where req_valid[i] = 0.
  - hold stalls a locked burst without releasing the lock.
  - Reset clears the lock.
- **When undefined:** the req_lock port is absent. Behaviour is pure round-robin as above.

## Test plan

- **Reset values:** assert rst asynchronously mid-cycle -> all outputs 0 immediately. Then release rst with all four requesters valid -> requester 0 is granted first.
- **Single write:** req 2 writes addr 5, data 0xABCDEF -> next cycle load = 8'b0010_0000, C_bus = 0xABCDEF, grant_id = 2, grant_valid = 1. Following cycle load = 0.
- **Round-robin:** requesters 0 and 1 held valid continuously for 6 cycles -> grant_id sequence 0,1,0,1,0,1 and one load pulse per cycle.
- **Hold:** hold high for 3 cycles with req 3 valid -> req_ready = 0 and load = 0 for those cycles. Accept occurs on the first edge after hold falls.
- **Address error:** with NUM_REG = 6, req 1 writes addr 7 -> load = 0, addr_err pulses for 1 cycle, req_ready = 1 (the write is consumed).
- **Lock (GPR_ARB_LOCK_EN):** req 0 issues 3 writes with lock = 1,1,0 while req 1 is valid throughout -> grants 0,0,0, then 1.
